// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one read or write access to an asynchronous 16-bit SRAM.
//
// Each access moves through SETUP, ACCESS (WAIT_CYCLES cycles) and, for writes, HOLD,
// then finishes in DONE with a one-cycle ready pulse. A request with no byte enables
// skips the SRAM and goes straight to DONE. All outputs are registered images of the
// FSM state, so they lag the state register by one cycle.
//
// Ports:
//   clk_i        system clock, rising edge
//   reset_i      synchronous active-high reset
//   req_i        access request, sampled only in IDLE
//   wr_i         1 = write, 0 = read (sampled with req_i)
//   addr_i       20-bit word address (sampled with req_i)
//   wdata_i      write data (sampled with req_i)
//   byte_en_i    byte enables, [1] = upper, [0] = lower (sampled with req_i)
//   dq_in_i      data returned from the SRAM bus
//   rdata_o      read data, held until the next read completes
//   ready_o      one-cycle completion pulse
//   busy_o       high whenever an access is in flight
//   mem_a_o      SRAM address
//   mem_ce_o, mem_ub_o, mem_lb_o, mem_oe_o, mem_we_o   active-low SRAM strobes
//   dq_out_o     data driven toward the SRAM
//   dq_oe_o      1 = dq_out_o drives the SRAM bus

module mem_access_ctrl #(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        req_i,
   input  logic        wr_i,
   input  logic [19:0] addr_i,
   input  logic [15:0] wdata_i,
   input  logic [1:0]  byte_en_i,
   input  logic [15:0] dq_in_i,
   output logic [15:0] rdata_o,
   output logic        ready_o,
   output logic        busy_o,
   output logic [19:0] mem_a_o,
   output logic        mem_ce_o,
   output logic        mem_ub_o,
   output logic        mem_lb_o,
   output logic        mem_oe_o,
   output logic        mem_we_o,
   output logic [15:0] dq_out_o,
   output logic        dq_oe_o
);

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StAccess,
      StHold,
      StDone
   } state_e;

   localparam logic [3:0] CntLoad = 4'(WAIT_CYCLES - 1);

   state_e      state_q;
   logic [3:0]  cnt_q;
   logic        wr_q;
   logic [19:0] addr_q;
   logic [15:0] wdata_q;
   logic [1:0]  be_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= StIdle;
         cnt_q    <= 4'd0;
         wr_q     <= 1'b0;
         addr_q   <= 20'd0;
         wdata_q  <= 16'd0;
         be_q     <= 2'b00;
         rdata_o  <= 16'd0;
         ready_o  <= 1'b0;
         busy_o   <= 1'b0;
         mem_a_o  <= 20'd0;
         mem_ce_o <= 1'b1;
         mem_ub_o <= 1'b1;
         mem_lb_o <= 1'b1;
         mem_oe_o <= 1'b1;
         mem_we_o <= 1'b1;
         dq_out_o <= 16'd0;
         dq_oe_o  <= 1'b0;
      end else begin
         // State sequencing
         unique case (state_q)
            StIdle: begin
               if (req_i) begin
                  // be_q = 00 also marks a bypass so DONE leaves rdata alone
                  wr_q    <= wr_i;
                  addr_q  <= addr_i;
                  wdata_q <= wdata_i;
                  be_q    <= byte_en_i;
                  state_q <= (byte_en_i == 2'b00) ? StDone : StSetup;
               end
            end
            StSetup: begin
               cnt_q   <= CntLoad;
               state_q <= StAccess;
            end
            StAccess: begin
               if (cnt_q == 4'd0) begin
                  state_q <= wr_q ? StHold : StDone;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            StHold:  state_q <= StDone;
            StDone:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase

         // Registered outputs: image of the state held during this cycle
         ready_o  <= 1'b0;
         busy_o   <= (state_q != StIdle);
         mem_ce_o <= 1'b1;
         mem_ub_o <= 1'b1;
         mem_lb_o <= 1'b1;
         mem_oe_o <= 1'b1;
         mem_we_o <= 1'b1;
         dq_oe_o  <= 1'b0;
         unique case (state_q)
            StSetup, StAccess: begin
               mem_ce_o <= 1'b0;
               mem_a_o  <= addr_q;
               mem_ub_o <= ~be_q[1];
               mem_lb_o <= ~be_q[0];
               if (wr_q) begin
                  dq_oe_o  <= 1'b1;
                  dq_out_o <= wdata_q;
                  mem_we_o <= (state_q == StSetup);
               end else begin
                  mem_oe_o <= 1'b0;
               end
            end
            StHold: begin
               mem_ce_o <= 1'b0;
               mem_ub_o <= ~be_q[1];
               mem_lb_o <= ~be_q[0];
               dq_oe_o  <= 1'b1;
            end
            StDone: begin
               ready_o <= 1'b1;
               // dq_in_i here is what the SRAM drove during the last ACCESS output cycle
               if (!wr_q && (be_q != 2'b00)) begin
                  rdata_o <= {(be_q[1] ? dq_in_i[15:8] : 8'h00),
                              (be_q[0] ? dq_in_i[7:0]  : 8'h00)};
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized accesses
// compared cycle by cycle against an expected timeline built from latency rules.

module tb_mem_access_ctrl;

   localparam int unsigned W = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic        wr;
   logic [19:0] addr;
   logic [15:0] wdata;
   logic [1:0]  byte_en;
   logic [15:0] dq_in;
   logic [15:0] rdata;
   logic        ready;
   logic        busy;
   logic [19:0] mem_a;
   logic        mem_ce;
   logic        mem_ub;
   logic        mem_lb;
   logic        mem_oe;
   logic        mem_we;
   logic [15:0] dq_out;
   logic        dq_oe;

   int n_tests = 0;
   int n_fail  = 0;

   // Model of values that persist between accesses
   logic [15:0] m_rdata;
   logic [19:0] m_addr;
   logic [15:0] m_dqout;

   always #5 clk = ~clk;

   mem_access_ctrl #(.WAIT_CYCLES(W)) dut (
      .clk_i     (clk),
      .reset_i   (reset),
      .req_i     (req),
      .wr_i      (wr),
      .addr_i    (addr),
      .wdata_i   (wdata),
      .byte_en_i (byte_en),
      .dq_in_i   (dq_in),
      .rdata_o   (rdata),
      .ready_o   (ready),
      .busy_o    (busy),
      .mem_a_o   (mem_a),
      .mem_ce_o  (mem_ce),
      .mem_ub_o  (mem_ub),
      .mem_lb_o  (mem_lb),
      .mem_oe_o  (mem_oe),
      .mem_we_o  (mem_we),
      .dq_out_o  (dq_out),
      .dq_oe_o   (dq_oe)
   );

   function automatic logic [7:0] ctl_vec();
      return {ready, busy, mem_ce, mem_ub, mem_lb, mem_oe, mem_we, dq_oe};
   endfunction

   // Entered at a negedge with the controller idle; returns at the negedge of the ready
   // cycle with req low, so a following call issues a back-to-back request.
   task automatic run_access(input logic wr_v, input logic [19:0] a, input logic [15:0] wd,
                             input logic [1:0] be, input bit noise, input bit rnd_dq,
                             input logic [15:0] dq_val);
      int          lat;
      bit          act, mid;
      logic [15:0] cap;
      logic [7:0]  exp_ctl;
      logic [19:0] exp_a;
      logic [15:0] exp_dq, exp_rd;
      act = (be != 2'b00);
      lat = !act ? 1 : (wr_v ? int'(W) + 3 : int'(W) + 2);
      cap = 16'h0;
      req = 1'b1; wr = wr_v; addr = a; wdata = wd; byte_en = be;
      @(posedge clk);
      for (int k = 0; k <= lat; k++) begin
         @(negedge clk);
         mid     = act && (k >= 1) && (k < lat);
         exp_ctl = {k == lat, k >= 1, !mid, !(mid && be[1]), !(mid && be[0]),
                    !(act && !wr_v && k >= 1 && k <= int'(W) + 1),
                    !(act && wr_v && k >= 2 && k <= int'(W) + 1),
                    mid && wr_v};
         exp_a   = (act && k >= 1) ? a : m_addr;
         exp_dq  = (act && wr_v && k >= 1) ? wd : m_dqout;
         exp_rd  = (k == lat && act && !wr_v) ?
                   {(be[1] ? cap[15:8] : 8'h00), (be[0] ? cap[7:0] : 8'h00)} : m_rdata;
         n_tests++;
         if (ctl_vec() !== exp_ctl) begin
            n_fail++;
            $display("FAIL ctl k=%0d wr=%0b be=%b: got %b want %b", k, wr_v, be, ctl_vec(),
                     exp_ctl);
         end
         n_tests++;
         if (mem_a !== exp_a || dq_out !== exp_dq) begin
            n_fail++;
            $display("FAIL addr/dq_out k=%0d: got %h/%h want %h/%h", k, mem_a, dq_out, exp_a,
                     exp_dq);
         end
         n_tests++;
         if (rdata !== exp_rd) begin
            n_fail++;
            $display("FAIL rdata k=%0d be=%b: got %h want %h", k, be, rdata, exp_rd);
         end
         n_tests++;
         if ((!mem_oe && !mem_we) || (!mem_oe && dq_oe)) begin
            n_fail++;
            $display("FAIL strobe_conflict k=%0d: got oe=%b we=%b dq_oe=%b want no overlap",
                     k, mem_oe, mem_we, dq_oe);
         end
         dq_in = rnd_dq ? 16'($urandom) : dq_val;
         if (k == int'(W) + 1) cap = dq_in;
         if (noise && k < lat) begin
            req = 1'($urandom); wr = 1'($urandom); addr = 20'($urandom);
            wdata = 16'($urandom); byte_en = 2'($urandom);
         end else begin
            req = 1'b0;
         end
      end
      if (act) begin
         m_addr = a;
         if (wr_v) m_dqout = wd;
         else m_rdata = {(be[1] ? cap[15:8] : 8'h00), (be[0] ? cap[7:0] : 8'h00)};
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         n_tests++;
         if (ctl_vec() !== 8'b0011_1110 || rdata !== m_rdata) begin
            n_fail++;
            $display("FAIL idle: got ctl=%b rdata=%h want ctl=00111110 rdata=%h", ctl_vec(),
                     rdata, m_rdata);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; req = 1'b0; wr = 1'b0; addr = '0; wdata = '0; byte_en = '0; dq_in = '0;
      repeat (2) @(negedge clk);
      n_tests++;
      if (ctl_vec() !== 8'b0011_1110 || rdata !== 16'h0 || mem_a !== 20'h0 ||
          dq_out !== 16'h0) begin
         n_fail++;
         $display("FAIL reset: got ctl=%b rdata=%h a=%h dq=%h want 00111110/0/0/0", ctl_vec(),
                  rdata, mem_a, dq_out);
      end
      reset = 1'b0;
      m_rdata = '0; m_addr = '0; m_dqout = '0;
      idle_cycles(2);
   endtask

   task automatic test_read_basic();
      run_access(1'b0, 20'h00012, 16'h0, 2'b11, 1'b0, 1'b0, 16'hBEEF);
      n_tests++;
      if (rdata !== 16'hBEEF) begin
         n_fail++;
         $display("FAIL read_basic: got %h want beef", rdata);
      end
      idle_cycles(1);
   endtask

   task automatic test_write_basic();
      run_access(1'b1, 20'h0FFFF, 16'h1234, 2'b11, 1'b0, 1'b1, 16'h0);
      idle_cycles(1);
   endtask

   task automatic test_byte_lane();
      run_access(1'b0, 20'h00abc, 16'h0, 2'b01, 1'b0, 1'b0, 16'hA55A);
      n_tests++;
      if (rdata !== 16'h005A) begin
         n_fail++;
         $display("FAIL byte_lane_lo: got %h want 005a", rdata);
      end
      run_access(1'b0, 20'h00abd, 16'h0, 2'b10, 1'b0, 1'b0, 16'hA55A);
      n_tests++;
      if (rdata !== 16'hA500) begin
         n_fail++;
         $display("FAIL byte_lane_hi: got %h want a500", rdata);
      end
      idle_cycles(1);
   endtask

   task automatic test_bypass();
      run_access(1'b0, 20'h12345, 16'h0, 2'b00, 1'b0, 1'b1, 16'h0);
      run_access(1'b1, 20'h54321, 16'hFFFF, 2'b00, 1'b0, 1'b1, 16'h0);
      idle_cycles(1);
   endtask

   task automatic test_reset_mid_write();
      req = 1'b1; wr = 1'b1; addr = 20'h0F0F0; wdata = 16'hCAFE; byte_en = 2'b11;
      @(posedge clk);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         req = 1'b0;
      end
      // Now in the second ACCESS output cycle
      n_tests++;
      if (mem_we !== 1'b0 || dq_oe !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_write_pos: got we=%b dq_oe=%b want 0/1", mem_we, dq_oe);
      end
      reset = 1'b1;
      @(negedge clk);
      n_tests++;
      if (ctl_vec() !== 8'b0011_1110 || rdata !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_mid_write: got ctl=%b rdata=%h want 00111110/0000", ctl_vec(),
                  rdata);
      end
      reset = 1'b0;
      m_rdata = '0; m_addr = '0; m_dqout = '0;
      idle_cycles(4);
   endtask

   task automatic test_reset_priority();
      reset = 1'b1; req = 1'b1; wr = 1'b0; addr = 20'h1; byte_en = 2'b11;
      @(negedge clk);
      reset = 1'b0; req = 1'b0;
      idle_cycles(3);
   endtask

   task automatic test_back_to_back();
      run_access(1'b0, 20'h00100, 16'h0, 2'b11, 1'b0, 1'b1, 16'h0);
      run_access(1'b0, 20'h00101, 16'h0, 2'b11, 1'b1, 1'b1, 16'h0);
      run_access(1'b1, 20'h00102, 16'h7777, 2'b10, 1'b1, 1'b1, 16'h0);
      idle_cycles(1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         run_access(1'($urandom), 20'($urandom), 16'($urandom),
                    ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3)),
                    1'($urandom), 1'b1, 16'h0);
         idle_cycles(int'($urandom_range(0, 2)));
      end
   endtask

   initial begin
      test_reset();
      test_read_basic();
      test_write_basic();
      test_byte_lane();
      test_bypass();
      test_reset_mid_write();
      test_reset_priority();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
